// File: rtl/alu_seq_pkg.sv
// alu_seq shared types and constants: FSM state, op codes, widths.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned NREGS  = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_e;

  // op = {l, ALUOp[1:0]}; any op with bit 2 set is a logic op
  localparam logic [OP_W-1:0] OP_NEGA  = 3'b000;
  localparam logic [OP_W-1:0] OP_NEGB  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b011;
  localparam logic [OP_W-1:0] OP_LOGIC = 3'b100;

endpackage

// File: rtl/alu_seq_if.sv
// Command/response bundle of alu_seq. master = control path, slave = sequencer.
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [IDX_W-1:0]  cmd_rd;
  logic [IDX_W-1:0]  cmd_rs1;
  logic [IDX_W-1:0]  cmd_rs2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [2:0]        flags;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, flags
  );

endinterface

// File: rtl/alu_seq_regfile.sv
// 16x4 register file: two combinational read ports, a debug read port,
// one synchronous write port, asynchronous clear.
// ALU_SEQ_R0ZERO_EN: writes to register 0 are dropped, so it always reads 0.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic              wr_ok;

`ifdef ALU_SEQ_R0ZERO_EN
  assign wr_ok = (waddr != '0);
`else
  assign wr_ok = 1'b1;
`endif

  assign rdata_a  = mem_q[raddr_a];
  assign rdata_b  = mem_q[raddr_b];
  assign dbg_data = mem_q[dbg_addr];

  // Next-state of the array: single write when enabled
  always_comb begin
    mem_d = mem_q;
    if (we && wr_ok) mem_d[waddr] = wdata;
  end

  // Storage with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle issue sequencer for the external 4-bit ALU.
// IDLE -> READ (operand fetch) -> EXEC (writeback) -> RESP (handshake).
// Optional macro ALU_SEQ_R0ZERO_EN hardwires register 0 to zero.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  alu_seq_if.slave          bus,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [1:0]        alu_ALUOp,
  output logic              alu_l,
  input  logic [DATA_W-1:0] alu_R,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_sign,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   cmd_op_q, cmd_op_d;
  logic [IDX_W-1:0]  rd_q, rd_d;
  logic [IDX_W-1:0]  rs1_q, rs1_d;
  logic [IDX_W-1:0]  rs2_q, rs2_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]        flags_q, flags_d;
  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;

  alu_seq_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (alu_R),
    .raddr_a  (rs1_q),
    .rdata_a  (rf_rdata_a),
    .raddr_b  (rs2_q),
    .rdata_b  (rf_rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Sequencer FSM and datapath next-state.
  // The ALU-facing op is a separate register loaded in READ, so the ALU
  // inputs change only at READ and stay glitch-free between commands.
  always_comb begin
    state_d    = state_q;
    cmd_op_d   = cmd_op_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    flags_d    = flags_q;
    rf_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_op_d = bus.cmd_op;
          rd_d     = bus.cmd_rd;
          rs1_d    = bus.cmd_rs1;
          rs2_d    = bus.cmd_rs2;
          state_d  = READ;
        end
      end
      READ: begin
        a_d      = rf_rdata_a;
        b_d      = rf_rdata_b;
        alu_op_d = cmd_op_q;
        state_d  = EXEC;
      end
      EXEC: begin
        rf_we      = 1'b1;
        rsp_data_d = alu_R;
        flags_d    = {alu_zero, alu_carry, alu_sign};
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_op_q   <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_op_q   <= cmd_op_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      flags_q    <= flags_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.flags     = flags_q;
  assign alu_A         = a_q;
  assign alu_B         = b_q;
  assign alu_ALUOp     = alu_op_q[1:0];
  assign alu_l         = alu_op_q[2];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a behavioural ALU and reference model.
// Honours ALU_SEQ_R0ZERO_EN in the reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] alu_A, alu_B, alu_R, dbg_addr, dbg_data;
  logic [1:0] alu_ALUOp;
  logic       alu_l, alu_zero, alu_carry, alu_sign;
  logic       seed_en;
  logic [3:0] seed_val;
  logic [3:0] ref_rf [16];
  int         tests = 0;
  int         fails = 0;

  alu_seq_if bus ();

  alu_seq dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .alu_A     (alu_A),
    .alu_B     (alu_B),
    .alu_ALUOp (alu_ALUOp),
    .alu_l     (alu_l),
    .alu_R     (alu_R),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .alu_sign  (alu_sign),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #50 clk = ~clk;

  // ALU behaviour: returns {zero, carry, sign, R}
  function automatic logic [6:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    c = 1'b0;
    if (op[2]) begin
      case (op[1:0])
        2'b00:   r = a & b;
        2'b01:   r = a | b;
        2'b10:   r = a ^ b;
        default: r = ~a;
      endcase
    end else begin
      case (op[1:0])
        2'b00:   r = 4'(0 - a);
        2'b01:   r = 4'(0 - b);
        2'b10:   begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
        default: begin r = 4'(a - b); c = (a < b); end
      endcase
    end
    return {(r == 4'd0), c, r[3], r};
  endfunction

  function automatic logic [6:0] seeded(input logic [3:0] v);
    return {(v == 4'd0), 1'b0, v[3], v};
  endfunction

  // External ALU stand-in; seed_en forces a chosen result to preload registers
  always_comb begin
    if (seed_en) {alu_zero, alu_carry, alu_sign, alu_R} = seeded(seed_val);
    else         {alu_zero, alu_carry, alu_sign, alu_R} = alu_ref({alu_l, alu_ALUOp}, alu_A, alu_B);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_write(input logic [3:0] rd, input logic [3:0] v);
`ifdef ALU_SEQ_R0ZERO_EN
    if (rd != 4'd0) ref_rf[rd] = v;
`else
    ref_rf[rd] = v;
`endif
  endtask

  task automatic dbg_scan(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check(tag, {4'd0, dbg_data}, {4'd0, ref_rf[i]});
    end
  endtask

  // One full command; response held off for 'hold' cycles with a rival cmd_valid
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic sen, input logic [3:0] sval, input int hold);
    logic [6:0] e;
    e = sen ? seeded(sval) : alu_ref(op, ref_rf[rs1], ref_rf[rs2]);
    seed_en       = sen;
    seed_val      = sval;
    dbg_addr      = rd;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    check("ready_idle", {7'd0, bus.cmd_ready}, 8'd1);
    tick();
    bus.cmd_valid = 1'b0;
    check("ready_read", {7'd0, bus.cmd_ready}, 8'd0);
    check("valid_read", {7'd0, bus.rsp_valid}, 8'd0);
    tick();
    check("alu_a", {4'd0, alu_A}, {4'd0, ref_rf[rs1]});
    check("alu_b", {4'd0, alu_B}, {4'd0, ref_rf[rs2]});
    check("alu_op", {5'd0, alu_l, alu_ALUOp}, {5'd0, op});
    check("valid_exec", {7'd0, bus.rsp_valid}, 8'd0);
    tick();
    ref_write(rd, e[3:0]);
    check("valid_resp", {7'd0, bus.rsp_valid}, 8'd1);
    check("rsp_data", {4'd0, bus.rsp_data}, {4'd0, e[3:0]});
    check("flags", {5'd0, bus.flags}, {5'd0, e[6:4]});
    check("dbg_wb", {4'd0, dbg_data}, {4'd0, ref_rf[rd]});
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_rd    = rd + 4'd1;
      tick();
      check("hold_valid", {7'd0, bus.rsp_valid}, 8'd1);
      check("hold_data", {4'd0, bus.rsp_data}, {4'd0, e[3:0]});
      check("hold_ready", {7'd0, bus.cmd_ready}, 8'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    seed_en       = 1'b0;
    check("ret_ready", {7'd0, bus.cmd_ready}, 8'd1);
    check("ret_valid", {7'd0, bus.rsp_valid}, 8'd0);
  endtask

  initial begin
    reset         = 1'b1;
    seed_en       = 1'b0;
    seed_val      = '0;
    dbg_addr      = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_rd    = '0;
    bus.cmd_rs1   = '0;
    bus.cmd_rs2   = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) ref_rf[i] = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    dbg_scan("rst_dbg");
    check("rst_ready", {7'd0, bus.cmd_ready}, 8'd1);
    check("rst_valid", {7'd0, bus.rsp_valid}, 8'd0);
    check("rst_flags", {5'd0, bus.flags}, 8'd0);

    // Preload r1=5, r2=3, then directed arithmetic
    do_cmd(OP_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 4'd5, 0);
    do_cmd(OP_ADD, 4'd2, 4'd0, 4'd0, 1'b1, 4'd3, 0);
    do_cmd(OP_ADD, 4'd4, 4'd1, 4'd2, 1'b0, 4'd0, 0);
    check("add_r4", {4'd0, ref_rf[4]}, 8'd8);
    do_cmd(OP_SUB, 4'd5, 4'd2, 4'd1, 1'b0, 4'd0, 0);
    do_cmd(OP_SUB, 4'd6, 4'd1, 4'd1, 1'b0, 4'd0, 0);
    do_cmd(OP_ADD, 4'd8, 4'd4, 4'd1, 1'b0, 4'd0, 10);
    dbg_scan("post_hold");

    // Reset asserted during EXEC of a write to r7
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_rd    = 4'd7;
    bus.cmd_rs1   = 4'd1;
    bus.cmd_rs2   = 4'd2;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("mid_ready", {7'd0, bus.cmd_ready}, 8'd1);
    check("mid_valid", {7'd0, bus.rsp_valid}, 8'd0);
    check("mid_data", {4'd0, bus.rsp_data}, 8'd0);
    check("mid_flags", {5'd0, bus.flags}, 8'd0);
    check("mid_ab", {alu_A, alu_B}, 8'd0);
    check("mid_op", {5'd0, alu_l, alu_ALUOp}, 8'd0);
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) ref_rf[i] = '0;
    dbg_scan("mid_dbg");

    // Normal operation after reset, then register-0 behaviour
    do_cmd(OP_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 4'd5, 0);
    do_cmd(OP_ADD, 4'd3, 4'd0, 4'd0, 1'b1, 4'd1, 1);
    do_cmd(OP_ADD, 4'd0, 4'd1, 4'd3, 1'b0, 4'd0, 0);
    dbg_addr = 4'd0;
    #1;
`ifdef ALU_SEQ_R0ZERO_EN
    check("r0_dbg", {4'd0, dbg_data}, 8'd0);
`else
    check("r0_dbg", {4'd0, dbg_data}, 8'd6);
`endif

    // Randomized commands with random back-pressure
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      logic [3:0] rd, rs1, rs2, sv;
      logic       se;
      op  = 3'($urandom_range(0, 7));
      rd  = 4'($urandom_range(0, 15));
      rs1 = 4'($urandom_range(0, 15));
      rs2 = 4'($urandom_range(0, 15));
      se  = ($urandom_range(0, 3) == 0);
      sv  = 4'($urandom_range(0, 15));
      do_cmd(op, rd, rs1, rs2, se, sv, int'($urandom_range(0, 3)));
    end
    dbg_scan("final_dbg");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle issue sequencer driving the 4-bit ALU from the command side. Accepts one operation command per handshake, reads two 4-bit operands from an internal 16x4 register file, presents them with the op code to the ALU, and writes the result back. It updates a flag register from the ALU's zero/carry/sign outputs and returns a response. The block sits between the control path and the ALU, which is instantiated outside it and wired through the alu_* ports.

## Interface
- Parameters: none (widths fixed: data 4, register index 4, op 3).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  {l, ALUOp[1:0]}, passed unchanged to the ALU.
- cmd_rd, cmd_rs1, cmd_rs2  in  4 each  destination, operand-A and operand-B register indices.
- alu_A, alu_B  out  4 each  ALU operands.
- alu_ALUOp  out  2  ALU operation select; alu_l  out  1  logic/arithmetic select.
- alu_R  in  4  ALU result; alu_zero, alu_carry, alu_sign  in  1 each  ALU flags.
- rsp_valid  out  1  response available; rsp_ready  in  1  response consumed.
- rsp_data  out  4  result written to rd; flags  out  3  {zero, carry, sign} of the last completed op.
- dbg_addr  in  4 / dbg_data  out  4  combinational register-file read port.

## Operation
- FSM states: IDLE, READ, EXEC, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch op/rd/rs1/rs2 and go to READ. Otherwise stay.
- READ: latch regfile[rs1] into alu_A and regfile[rs2] into alu_B. Go to EXEC.
- EXEC: alu_A, alu_B, alu_ALUOp and alu_l are stable. At the clock edge: regfile[rd] <= alu_R; rsp_data <= alu_R; flags <= {alu_zero, alu_carry, alu_sign}. Go to RESP.
- RESP: rsp_valid=1. Hold rsp_data. Go to IDLE on rsp_ready; stay otherwise.
- Operands and op hold their values from READ until the next command's READ. The ALU sees no glitches between commands.
- rs1, rs2 and rd may alias. Reads complete before the writeback, so there is no hazard.
- Reset (any time, including mid-operation): state=IDLE. All 16 registers=0. alu_A=alu_B=0, alu_ALUOp=0, alu_l=0, rsp_data=0, flags=0. rsp_valid=0, cmd_ready=1 (IDLE). The in-flight command is dropped and its writeback is not performed.
- Register-file writes happen only on the EXEC edge.

## Timing
- Command accepted at edge E0. READ occupies E0–E1, EXEC occupies E1–E2, writeback happens at E2, and rsp_valid rises after E2.
- Minimum command-to-command spacing is 4 cycles (IDLE, READ, EXEC, RESP with rsp_ready already high).
- cmd_ready is low from the edge after acceptance until return to IDLE.
- rsp_valid stays asserted until the cycle in which rsp_ready=1. Back-pressure has no bound.
- dbg_data reflects a write on the cycle after the EXEC edge.
- The ALU path is purely combinational and must settle within the single EXEC cycle.

## Configuration
- ALU_SEQ_R0ZERO_EN defined: register 0 always reads 0. Writes with rd=0 are discarded, but rsp_data and flags still update. dbg_data for address 0 is 0.
- ALU_SEQ_R0ZERO_EN undefined: register 0 is an ordinary read/write register.

## Structure
- Package alu_seq_pkg holds:
  - the state enum (IDLE, READ, EXEC, RESP);
  - op constants: OP_NEGA=3'b000, OP_NEGB=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, logic ops 3'b1xx;
  - width localparams (DATA_W=4, IDX_W=4).
- One sub-module: alu_seq_regfile. It is 16x4 with two combinational read ports plus the dbg port, one synchronous write port, and asynchronous clear on reset.
- The ALU is not instantiated inside alu_seq. The bench connects the team's alu module to the alu_* ports.

## Test plan
- Reset then dbg scan of all 16 addresses -> every dbg_data=0; cmd_ready=1, rsp_valid=0, flags=3'b000.
- Preload r1=5 and r2=3 (via OP_ADD from r0 after seeding), then OP_ADD rd=4, rs1=1, rs2=2 -> rsp_data=4'b1000 exactly 3 cycles after acceptance; flags={0,0,1}; dbg r4=8.
- OP_SUB rd=5, rs1=2(=3), rs2=1(=5) -> rsp_data=4'b1110, sign=1, zero=0; then OP_SUB rd=6, rs1=1, rs2=1 -> rsp_data=0, zero=1.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stay stable, cmd_ready=0, a second cmd_valid is not accepted; release -> IDLE next cycle.
- Assert reset during EXEC of a write to r7 -> r7 stays 0 and all outputs take their reset values; the next command executes normally.
- With ALU_SEQ_R0ZERO_EN: OP_ADD rd=0 with result 6 -> rsp_data=6, dbg r0=0. Without the macro: dbg r0=6.
